timebase_sched: RTL and testbench

Timebase scheduler that derives the one-second, one-minute and one-hour tick pulses from the 50 MHz system clock. It sequences the LED controller and any other tick consumer in the timer subsystem. Software or buttons drive run, pause and clear commands, and the block also publishes the current seconds, minutes and hours counts. The block owns the tick outputs: downstream blocks only count ticks and never generate them.

---
 rtl/timebase_sched.sv | 97 +++++++++
 tb/tb_timebase_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/timebase_sched.sv
// timebase_sched: derives one-second/minute/hour tick pulses and time counts from the system clock
module timebase_sched #(
   parameter int CLK_FREQ_HZ  = 50_000_000,
   parameter int SEC_PER_MIN  = 60,
   parameter int MIN_PER_HOUR = 60,
   parameter int HOUR_PER_DAY = 24
) (
   input  logic       clk_50m,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   output logic       one_sec_timer,
   output logic       one_min_timer,
   output logic       one_hour_timer,
   output logic [5:0] sec_count,
   output logic [5:0] min_count,
   output logic [4:0] hour_count,
   output logic       running
);
   localparam int PW = $clog2(CLK_FREQ_HZ);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;
   state_t        r_state;
   logic [PW-1:0] r_ps;
   logic          r_sec_t, r_min_t, r_hour_t, r_running;
   logic [5:0]    r_sec, r_min;
   logic [4:0]    r_hour;
   logic          w_ps_wrap, w_sec_wrap, w_min_wrap, w_hour_wrap;
   assign w_ps_wrap   = r_ps == PW'(CLK_FREQ_HZ - 1);
   assign w_sec_wrap  = r_sec == 6'(SEC_PER_MIN - 1);
   assign w_min_wrap  = r_min == 6'(MIN_PER_HOUR - 1);
   assign w_hour_wrap = r_hour == 5'(HOUR_PER_DAY - 1);
   // Command FSM, prescaler and cascaded second/minute/hour counters; ticks are single-cycle pulses
   always_ff @(posedge clk_50m or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_ps      <= '0;
         r_sec_t   <= 1'b0;
         r_min_t   <= 1'b0;
         r_hour_t  <= 1'b0;
         r_sec     <= '0;
         r_min     <= '0;
         r_hour    <= '0;
         r_running <= 1'b0;
      end else begin
         r_sec_t  <= 1'b0;
         r_min_t  <= 1'b0;
         r_hour_t <= 1'b0;
         if (clear) begin
            r_state   <= ST_IDLE;
            r_ps      <= '0;
            r_sec     <= '0;
            r_min     <= '0;
            r_hour    <= '0;
            r_running <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: if (start) begin
                  r_state   <= ST_RUN;
                  r_ps      <= '0;
                  r_running <= 1'b1;
               end
               ST_RUN: if (stop) begin
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end else if (w_ps_wrap) begin
                  r_ps    <= '0;
                  r_sec_t <= 1'b1;
                  r_sec   <= w_sec_wrap ? '0 : r_sec + 6'(1);
                  if (w_sec_wrap) begin
                     r_min_t <= 1'b1;
                     r_min   <= w_min_wrap ? '0 : r_min + 6'(1);
                     if (w_min_wrap) begin
                        r_hour_t <= 1'b1;
                        r_hour   <= w_hour_wrap ? '0 : r_hour + 5'(1);
                     end
                  end
               end else begin
                  r_ps <= r_ps + PW'(1);
               end
               ST_PAUSE: if (start) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end
   assign one_sec_timer  = r_sec_t;
   assign one_min_timer  = r_min_t;
   assign one_hour_timer = r_hour_t;
   assign sec_count      = r_sec;
   assign min_count      = r_min;
   assign hour_count     = r_hour;
   assign running        = r_running;
endmodule

// File: tb/tb_timebase_sched.sv
// tb_timebase_sched: directed vector bench for the timebase scheduler with a small tick geometry
module tb_timebase_sched;
   logic       clk_50m, reset, start, stop, clear;
   logic       one_sec_timer, one_min_timer, one_hour_timer, running;
   logic [5:0] sec_count, min_count;
   logic [4:0] hour_count;
   logic [20:0] w_obs;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        st, sp, cl;
      int          n;
      logic [20:0] exp;
      string       name;
   } vec_t;
   vec_t tbl[$];

   timebase_sched #(.CLK_FREQ_HZ(10), .SEC_PER_MIN(4), .MIN_PER_HOUR(3), .HOUR_PER_DAY(2)) dut (
      .clk_50m(clk_50m), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .one_sec_timer(one_sec_timer), .one_min_timer(one_min_timer), .one_hour_timer(one_hour_timer),
      .sec_count(sec_count), .min_count(min_count), .hour_count(hour_count), .running(running)
   );

   assign w_obs = {one_sec_timer, one_min_timer, one_hour_timer, sec_count, min_count, hour_count, running};

   initial clk_50m = 1'b0;
   always #5 clk_50m = ~clk_50m;

   function automatic logic [20:0] ex(input logic st, mt, ht, input int sc, mc, hc, input logic r);
      return {st, mt, ht, 6'(sc), 6'(mc), 5'(hc), r};
   endfunction

   task automatic check(input string name, input logic [20:0] exp);
      logic [20:0] obs;
      obs = w_obs;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got ticks=%b%b%b s=%0d m=%0d h=%0d run=%b, want ticks=%b%b%b s=%0d m=%0d h=%0d run=%b",
                  name, obs[20], obs[19], obs[18], obs[17:12], obs[11:6], obs[5:1], obs[0],
                  exp[20], exp[19], exp[18], exp[17:12], exp[11:6], exp[5:1], exp[0]);
      end
   endtask

   task automatic edge_cmd(input logic s, p, c);
      start = s;
      stop  = p;
      clear = c;
      @(posedge clk_50m);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
   endtask

   task automatic add(input logic s, p, c, input int n, input logic [20:0] exp, input string name);
      vec_t v;
      v.st = s; v.sp = p; v.cl = c; v.n = n; v.exp = exp; v.name = name;
      tbl.push_back(v);
   endtask

   task automatic idle(input int n);
      repeat (n) edge_cmd(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      repeat (3) @(posedge clk_50m);
      #1;
      check("reset_values", ex(0, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         edge_cmd(1'b0, 1'b0, 1'b0);
         check("idle_after_reset", ex(0, 0, 0, 0, 0, 0, 0));
      end

      // free run from a start at edge 0; each entry is n edges with the command on the first one
      add(1, 0, 0,   1, ex(0, 0, 0, 0, 0, 0, 1), "start_e0");
      add(0, 0, 0,   9, ex(0, 0, 0, 0, 0, 0, 1), "e9_no_tick");
      add(0, 0, 0,   1, ex(1, 0, 0, 1, 0, 0, 1), "e10_sec");
      add(0, 0, 0,   1, ex(0, 0, 0, 1, 0, 0, 1), "e11_pulse_end");
      add(0, 0, 0,   9, ex(1, 0, 0, 2, 0, 0, 1), "e20_sec");
      add(0, 0, 0,  10, ex(1, 0, 0, 3, 0, 0, 1), "e30_sec");
      add(0, 0, 0,  10, ex(1, 1, 0, 0, 1, 0, 1), "e40_min");
      add(0, 0, 0,   1, ex(0, 0, 0, 0, 1, 0, 1), "e41_pulse_end");
      add(0, 0, 0,  39, ex(1, 1, 0, 0, 2, 0, 1), "e80_min");
      add(0, 0, 0,  40, ex(1, 1, 1, 0, 0, 1, 1), "e120_hour");
      add(1, 0, 0,   1, ex(0, 0, 0, 0, 0, 1, 1), "e121_start_in_run");
      add(0, 0, 0,   9, ex(1, 0, 0, 1, 0, 1, 1), "e130_sec");
      add(0, 0, 0, 110, ex(1, 1, 1, 0, 0, 0, 1), "e240_day_wrap");
      add(0, 0, 0,   1, ex(0, 0, 0, 0, 0, 0, 1), "e241_pulse_end");
      add(0, 0, 1,   1, ex(0, 0, 0, 0, 0, 0, 0), "clear_in_run");
      add(0, 1, 0,   1, ex(0, 0, 0, 0, 0, 0, 0), "stop_in_idle");
      foreach (tbl[k]) begin
         edge_cmd(tbl[k].st, tbl[k].sp, tbl[k].cl);
         idle(tbl[k].n - 1);
         check(tbl[k].name, tbl[k].exp);
      end

      // stop on the terminal-count edge suppresses the tick until the first RUN edge after resume
      edge_cmd(1'b1, 1'b0, 1'b0);
      idle(9);
      check("tc_before", ex(0, 0, 0, 0, 0, 0, 1));
      edge_cmd(1'b0, 1'b1, 1'b0);
      check("tc_stop_suppress", ex(0, 0, 0, 0, 0, 0, 0));
      edge_cmd(1'b0, 1'b1, 1'b0);
      check("stop_in_pause", ex(0, 0, 0, 0, 0, 0, 0));
      edge_cmd(1'b1, 1'b0, 1'b0);
      check("tc_resume", ex(0, 0, 0, 0, 0, 0, 1));
      idle(1);
      check("tc_late_tick", ex(1, 0, 0, 1, 0, 0, 1));
      idle(1);
      check("tc_late_end", ex(0, 0, 0, 1, 0, 0, 1));

      // pause: stop at edge 15 holds prescaler at 4, resume at 30, wrap on edge 36
      edge_cmd(1'b0, 1'b0, 1'b1);
      check("clear_before_pause", ex(0, 0, 0, 0, 0, 0, 0));
      edge_cmd(1'b1, 1'b0, 1'b0);
      idle(10);
      check("p_e10_sec", ex(1, 0, 0, 1, 0, 0, 1));
      idle(4);
      edge_cmd(1'b0, 1'b1, 1'b0);
      check("p_e15_stop", ex(0, 0, 0, 1, 0, 0, 0));
      for (int i = 16; i < 30; i++) begin
         edge_cmd(1'b0, 1'b0, 1'b0);
         check("p_paused", ex(0, 0, 0, 1, 0, 0, 0));
      end
      edge_cmd(1'b1, 1'b0, 1'b0);
      check("p_e30_resume", ex(0, 0, 0, 1, 0, 0, 1));
      for (int i = 31; i < 36; i++) begin
         edge_cmd(1'b0, 1'b0, 1'b0);
         check("p_resumed_wait", ex(0, 0, 0, 1, 0, 0, 1));
      end
      edge_cmd(1'b0, 1'b0, 1'b0);
      check("p_e36_sec", ex(1, 0, 0, 2, 0, 0, 1));

      // clear mid-run at edge 25, then clear and start together
      edge_cmd(1'b0, 1'b0, 1'b1);
      edge_cmd(1'b1, 1'b0, 1'b0);
      idle(10);
      check("c_e10_sec", ex(1, 0, 0, 1, 0, 0, 1));
      idle(10);
      check("c_e20_sec", ex(1, 0, 0, 2, 0, 0, 1));
      idle(4);
      edge_cmd(1'b0, 1'b0, 1'b1);
      check("c_e25_clear", ex(0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 30; i++) begin
         edge_cmd(1'b0, 1'b0, 1'b0);
         check("c_after_clear", ex(0, 0, 0, 0, 0, 0, 0));
      end
      edge_cmd(1'b1, 1'b0, 1'b1);
      check("c_clear_and_start", ex(0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++) begin
         edge_cmd(1'b0, 1'b0, 1'b0);
         check("c_stays_idle", ex(0, 0, 0, 0, 0, 0, 0));
      end

      // extra starts in RUN, then asynchronous reset mid-second after edge 16
      edge_cmd(1'b1, 1'b0, 1'b0);
      idle(4);
      edge_cmd(1'b1, 1'b0, 1'b0);
      idle(4);
      check("r_e9_no_tick", ex(0, 0, 0, 0, 0, 0, 1));
      idle(1);
      check("r_e10_sec", ex(1, 0, 0, 1, 0, 0, 1));
      idle(1);
      edge_cmd(1'b1, 1'b0, 1'b0);
      idle(4);
      check("r_e16", ex(0, 0, 0, 1, 0, 0, 1));
      #3 reset = 1'b1;
      #1;
      check("r_async_reset", ex(0, 0, 0, 0, 0, 0, 0));
      @(posedge clk_50m);
      #1 reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         edge_cmd(1'b0, 1'b0, 1'b0);
         check("r_needs_start", ex(0, 0, 0, 0, 0, 0, 0));
      end
      edge_cmd(1'b1, 1'b0, 1'b0);
      check("r_restart", ex(0, 0, 0, 0, 0, 0, 1));
      idle(9);
      check("r_restart_e9", ex(0, 0, 0, 0, 0, 0, 1));
      idle(1);
      check("r_restart_e10", ex(1, 0, 0, 1, 0, 0, 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
